// File: rtl/ps2_key_decoder_if.sv
// Key-state bus between the PS/2 decoder and the calculator FSMs.
// The decoder is the master: it consumes the raw PS/2 pins and produces the key state.
interface ps2_key_decoder_if;
    logic         ps2_clk;
    logic         ps2_data;
    logic         key_valid;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output key_valid,
        output key_down,
        output last_change,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  key_valid,
        input  key_down,
        input  last_change,
        input  frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode set 2 receiver and make/break decoder.
// Drives the key-state bus with key_valid, key_down, last_change and frame_err.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic               clk,
    input  logic               rst_n,
    ps2_key_decoder_if.master  bus
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CODE_W = 9;
    localparam int unsigned KEYS   = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_clk_s1, r_clk_s2, r_clk_prev;
    logic                r_dat_s1, r_dat_s2;
    logic [BYTE_W-1:0]   r_shift;
    logic [2:0]          r_bit;
    logic                r_par;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_byte_ok;
    logic                r_err_p;
    logic                r_ext, r_brk;
    logic                r_key_valid;
    logic [KEYS-1:0]     r_key_down;
    logic [CODE_W-1:0]   r_last_change;
    logic                r_frame_err;

    logic                w_fall;
    logic                w_dat;
    logic                w_timeout;
    logic                w_byte_ok;
    logic                w_err;
    logic                w_discard;
    logic [CODE_W-1:0]   w_code;

    // Two-flop synchronizers; reset to the idle-high line level so no false edge appears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= bus.ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_dat     = r_dat_s2;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_byte_ok = 1'b0;
        w_err     = 1'b0;
        if (w_timeout) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat) w_next = S_DATA;
                S_DATA:   if (r_bit == 3'd7) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP: begin
                    w_next = S_IDLE;
                    if (w_dat && (^{r_shift, r_par})) w_byte_ok = 1'b1;
                    else                             w_err     = 1'b1;
                end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Receive datapath: shift register, bit count, parity and inactivity counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit     <= '0;
            r_par     <= 1'b0;
            r_cnt     <= '0;
            r_byte_ok <= 1'b0;
            r_err_p   <= 1'b0;
        end else begin
            r_byte_ok <= w_byte_ok;
            r_err_p   <= w_err;
            if (r_state == S_IDLE || w_fall || w_timeout) r_cnt <= '0;
            else                                          r_cnt <= r_cnt + CNT_W'(1);
            if (w_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bit <= '0;
                    S_DATA: begin
                        r_shift <= {w_dat, r_shift[BYTE_W-1:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                    S_PARITY: r_par <= w_dat;
                    default:  ;
                endcase
            end
        end
    end

    assign w_code = {r_ext, r_shift};

    always_comb begin
        w_discard = 1'b0;
        case (r_shift)
            8'hE1, 8'hAA, 8'hFA, 8'hEE,
            8'hFC, 8'hFE, 8'h00, 8'hFF: w_discard = !r_ext && !r_brk;
            default:                     w_discard = 1'b0;
        endcase
    end

    // Decode stage: prefix tracking and key-state update one cycle after byte_ok
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_key_valid   <= 1'b0;
            r_key_down    <= '0;
            r_last_change <= '0;
            r_frame_err   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_frame_err <= r_err_p;
            if (r_err_p) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_ok) begin
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (!w_discard) begin
                    r_key_down[w_code] <= !r_brk;
                    r_last_change      <= w_code;
                    r_key_valid        <= 1'b1;
                    r_ext              <= 1'b0;
                    r_brk              <= 1'b0;
                end
            end
        end
    end

    assign bus.key_valid   = r_key_valid;
    assign bus.key_down    = r_key_down;
    assign bus.last_change = r_last_change;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios plus random frames
// checked against a byte-level behavioural model of the scancode rules.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int unsigned TO   = 300;
    localparam int unsigned HALF = 8;

    typedef struct {
        bit           is_err;
        logic [8:0]   lc;
        logic [511:0] kd;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ps2_key_decoder_if bus_if();

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    ev_t          exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [511:0] m_kd    = '0;
    logic [8:0]   m_lc    = '0;
    bit           m_ext   = 1'b0;
    bit           m_brk   = 1'b0;

    task automatic push_ev(input bit is_err);
        ev_t e;
        e.is_err = is_err;
        e.lc     = m_lc;
        e.kd     = m_kd;
        exp_q.push_back(e);
    endtask

    // Reference model of the make/break byte rules
    task automatic model_byte(input logic [7:0] b, input bit good);
        bit discard;
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            push_ev(1'b1);
            return;
        end
        discard = (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                   b == 8'hFC || b == 8'hFE || b == 8'h00 || b == 8'hFF) && !m_ext && !m_brk;
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (!discard) begin
            m_lc       = {m_ext, b};
            m_kd[m_lc] = !m_brk;
            m_ext      = 1'b0;
            m_brk      = 1'b0;
            push_ev(1'b0);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive nbits of an 11-bit frame; the model is updated as the stop edge is issued
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus_if.ps2_data = bits[i];
            wait_cyc(HALF);
            if (i == 10) model_byte(b, !bad_par && !bad_stop);
            bus_if.ps2_clk = 1'b0;
            wait_cyc(HALF);
            bus_if.ps2_clk = 1'b1;
        end
        bus_if.ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic wait_drain();
        int budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_zero(input string name);
        @(negedge clk);
        n_tests++;
        if (bus_if.key_valid !== 1'b0 || bus_if.frame_err !== 1'b0 ||
            bus_if.key_down !== '0 || bus_if.last_change !== 9'h000) begin
            n_fail++;
            $display("FAIL %s valid=%b err=%b lc=%h kd_nonzero=%b required all zero",
                     name, bus_if.key_valid, bus_if.frame_err, bus_if.last_change, |bus_if.key_down);
        end
    endtask

    task automatic check_kd_bit(input string name, input logic [8:0] code, input logic req);
        n_tests++;
        if (bus_if.key_down[code] !== req) begin
            n_fail++;
            $display("FAIL %s key_down[%h]=%b required %b", name, code, bus_if.key_down[code], req);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (bus_if.key_valid === 1'b1 || bus_if.frame_err === 1'b1)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output valid=%b err=%b lc=%h required no pulse",
                         bus_if.key_valid, bus_if.frame_err, bus_if.last_change);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({bus_if.key_valid, bus_if.frame_err} !== {~e.is_err, e.is_err}) begin
                    n_fail++;
                    $display("FAIL event_kind valid=%b err=%b required valid=%b err=%b",
                             bus_if.key_valid, bus_if.frame_err, ~e.is_err, e.is_err);
                end
                n_tests++;
                if (bus_if.last_change !== e.lc) begin
                    n_fail++;
                    $display("FAIL last_change got=%h required=%h", bus_if.last_change, e.lc);
                end
                n_tests++;
                if (bus_if.key_down !== e.kd) begin
                    n_fail++;
                    $display("FAIL key_down got=%h required=%h", bus_if.key_down, e.kd);
                end
            end
        end
    end

    initial begin
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        check_idle_zero("reset_state");

        // Plain make
        frame(8'h1C);
        wait_drain();
        // Extended make and extended break
        frame(8'hE0); frame(8'h5A);
        wait_drain();
        check_kd_bit("ext_make", 9'h15A, 1'b1);
        frame(8'hE0); frame(8'hF0); frame(8'h5A);
        wait_drain();
        check_kd_bit("ext_break", 9'h15A, 1'b0);
        check_kd_bit("ext_no_alias", 9'h05A, 1'b0);
        // Two keys, break one
        frame(8'h1B); frame(8'hF0); frame(8'h1C);
        wait_drain();
        check_kd_bit("multi_held", 9'h01B, 1'b1);
        // Bad parity, then bad stop on F0, then 2D must be a make
        send_frame(8'h3A, 1'b1, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        frame(8'h2D);
        wait_drain();
        check_kd_bit("brk_cleared_by_err", 9'h02D, 1'b1);
        // Typematic repeat, break of unheld key, discard bytes, prefixed "discard" byte
        frame(8'h2D); frame(8'hF0); frame(8'h33);
        frame(8'hAA); frame(8'hFA); frame(8'hE0); frame(8'h00);
        wait_drain();
        // Partial frame then timeout
        send_frame(8'h55, 1'b0, 1'b0, 5);
        model_byte(8'h00, 1'b0);
        wait_cyc(TO + 50);
        wait_drain();
        frame(8'h2D);
        wait_drain();

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1, 2:    b = 8'hF0;
                3:       b = 8'hAA;
                4:       b = 8'hFF;
                5:       b = 8'h1C;
                default: b = 8'(($urandom_range(0, 7) << 3) | $urandom_range(1, 7));
            endcase
            send_frame(b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 11);
        end
        wait_drain();

        // Reset mid-frame after a make
        frame(8'h5A);
        wait_drain();
        send_frame(8'h66, 1'b0, 1'b0, 4);
        bus_if.ps2_clk  = 1'b0;
        bus_if.ps2_data = 1'b0;
        rst_n = 1'b0;
        m_kd = '0; m_lc = '0; m_ext = 1'b0; m_brk = 1'b0;
        wait_cyc(3);
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        rst_n = 1'b1;
        wait_cyc(TO + 20);
        check_idle_zero("mid_frame_reset");
        frame(8'h1B);
        wait_drain();
        check_kd_bit("post_reset_make", 9'h01B, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
